// File: rtl/fq_pkg.sv
// Shared types and constants for the fair-queue flow bank.
package fq_pkg;

    localparam int unsigned DEF_FLOW_LOG2 = 3;
    localparam int unsigned DEF_LEN_W     = 16;
    localparam int unsigned NUM_FLOWS     = 2 ** DEF_FLOW_LOG2;
    localparam int unsigned COUNT_W       = 32;
    localparam logic [COUNT_W-1:0] NORM_STEP = 32'h4000_0000;

    typedef logic [DEF_FLOW_LOG2-1:0] flow_id_t;
    typedef logic [DEF_LEN_W-1:0]     len_t;
    typedef logic [COUNT_W-1:0]       count_t;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_NORM} state_t;

    // Subtract one normalisation step, clamping at zero.
    function automatic count_t norm_sub(input count_t v);
        return (v >= NORM_STEP) ? (v - NORM_STEP) : '0;
    endfunction

endpackage

// File: rtl/fq_flow_fifo.sv
// Per-flow descriptor FIFO; head is visible on dout while non-empty.
module fq_flow_fifo #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   occupancy
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   occ_q;
    logic                  do_push, do_pop;

    assign empty     = (occ_q == '0);
    assign full      = (occ_q == (DEPTH_LOG2 + 1)'(Depth));
    assign occupancy = occ_q;
    assign dout      = mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/fq_flow_bank.sv
// Per-flow descriptor store with service accounting; serves the scheduler's pick
// into a single output slot and charges the popped length to that flow.
module fq_flow_bank
    import fq_pkg::*;
#(
    parameter int unsigned NUM_IN_LOG2 = DEF_FLOW_LOG2,
    parameter int unsigned DEPTH_LOG2  = 2,
    parameter int unsigned LEN_W       = DEF_LEN_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enq_valid,
    output logic                                  enq_ready,
    input  logic [NUM_IN_LOG2-1:0]                enq_flow,
    input  logic [LEN_W-1:0]                      enq_len,
    output logic [2**NUM_IN_LOG2-1:0][COUNT_W-1:0] count,
    output logic [2**NUM_IN_LOG2-1:0]             valid_q,
    input  logic [NUM_IN_LOG2-1:0]                pick,
    input  logic                                  pick_valid,
    output logic                                  deq_valid,
    input  logic                                  deq_ready,
    output logic [NUM_IN_LOG2-1:0]                deq_flow,
    output logic [LEN_W-1:0]                      deq_len
);

    localparam int unsigned Nf   = 2 ** NUM_IN_LOG2;
    localparam int unsigned OccW = DEPTH_LOG2 + 1;

    logic [Nf-1:0]                push, pop, empty, full, valid_d;
    logic [Nf-1:0][LEN_W-1:0]     head;
    logic [Nf-1:0][OccW-1:0]      occ;
    logic [Nf-1:0][COUNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0]           vtime_q, vtime_d;
    state_t                       state_q, state_d;
    logic                         deq_valid_q, deq_valid_d;
    logic [NUM_IN_LOG2-1:0]       deq_flow_q, deq_flow_d;
    logic [LEN_W-1:0]             deq_len_q, deq_len_d;
    logic                         slot_free, serve, any_msb;

    assign enq_ready = !full[enq_flow];
    assign slot_free = !deq_valid_q || deq_ready;
    assign serve     = (state_q == S_IDLE) && pick_valid && slot_free && valid_q[pick];
    assign count     = count_q;
    assign deq_valid = deq_valid_q;
    assign deq_flow  = deq_flow_q;
    assign deq_len   = deq_len_q;

    for (genvar f = 0; f < Nf; f++) begin : g_flow
        assign push[f] = enq_valid && enq_ready && (enq_flow == NUM_IN_LOG2'(f));
        assign pop[f]  = serve && (pick == NUM_IN_LOG2'(f));

        fq_flow_fifo #(
            .DEPTH_LOG2 (DEPTH_LOG2),
            .WIDTH      (LEN_W)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[f]),
            .pop       (pop[f]),
            .din       (enq_len),
            .dout      (head[f]),
            .empty     (empty[f]),
            .full      (full[f]),
            .occupancy (occ[f])
        );
    end

    always_comb begin
        count_d = count_q;
        valid_d = '0;
        any_msb = 1'b0;
        for (int f = 0; f < Nf; f++) begin
            valid_d[f] = push[f] || (occ[f] > OccW'(pop[f]));
            any_msb    = any_msb | count_q[f][COUNT_W-1];
            if (pop[f]) begin
                count_d[f] = count_q[f] + COUNT_W'(head[f]);
            end else if (push[f] && empty[f]) begin
                // A newly active flow starts no lower than virtual time: no banked credit.
                count_d[f] = (count_q[f] > vtime_q) ? count_q[f] : vtime_q;
            end
            if (state_q == S_NORM) count_d[f] = norm_sub(count_d[f]);
        end
    end

    always_comb begin
        state_d     = state_q;
        vtime_d     = vtime_q;
        deq_valid_d = deq_valid_q;
        deq_flow_d  = deq_flow_q;
        deq_len_d   = deq_len_q;
        if (serve) begin
            deq_valid_d = 1'b1;
            deq_flow_d  = pick;
            deq_len_d   = head[pick];
        end else if (deq_ready) begin
            deq_valid_d = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (serve) begin
                    state_d = S_HOLD;
                    vtime_d = count_q[pick];
                end
            end
            // Absorbs the scheduler's registered pick so it is never served twice.
            S_HOLD:  state_d = any_msb ? S_NORM : S_IDLE;
            S_NORM: begin
                state_d = S_IDLE;
                vtime_d = norm_sub(vtime_q);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            valid_q     <= '0;
            vtime_q     <= '0;
            deq_valid_q <= 1'b0;
            deq_flow_q  <= '0;
            deq_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            vtime_q     <= vtime_d;
            deq_valid_q <= deq_valid_d;
            deq_flow_q  <= deq_flow_d;
            deq_len_q   <= deq_len_d;
        end
    end

endmodule

// File: tb/tb_fq_flow_bank.sv
// Directed bench for fq_flow_bank: ordering, back-pressure, fairness, normalisation.
module tb_fq_flow_bank;

    logic              clk;
    logic              rst;
    logic              enq_valid;
    logic              enq_ready;
    logic [2:0]        enq_flow;
    logic [15:0]       enq_len;
    logic [7:0][31:0]  count;
    logic [7:0]        valid_q;
    logic [2:0]        pick;
    logic              pick_valid;
    logic              deq_valid;
    logic              deq_ready;
    logic [2:0]        deq_flow;
    logic [15:0]       deq_len;

    int checks = 0;
    int errors = 0;

    fq_flow_bank #(
        .NUM_IN_LOG2 (3),
        .DEPTH_LOG2  (2),
        .LEN_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_flow   (enq_flow),
        .enq_len    (enq_len),
        .count      (count),
        .valid_q    (valid_q),
        .pick       (pick),
        .pick_valid (pick_valid),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_flow   (deq_flow),
        .deq_len    (deq_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers; both start and end on a falling edge.
    task automatic enq(input logic [2:0] f, input logic [15:0] l);
        enq_valid = 1'b1;
        enq_flow  = f;
        enq_len   = l;
        @(negedge clk);
        enq_valid = 1'b0;
    endtask

    task automatic serve(input logic [2:0] f);
        pick       = f;
        pick_valid = 1'b1;
        @(negedge clk);
        pick_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; enq_valid = 1'b1; enq_flow = 3'd0; enq_len = 16'd7;
        repeat (3) @(negedge clk);
        rst = 1'b0; enq_valid = 1'b0;
        checks++;
        if (deq_valid !== 1'b0) begin
            errors++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid);
        end
        checks++;
        if (valid_q !== 8'h00) begin
            errors++; $display("FAIL reset_valid_q: got %h want 00", valid_q);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (count[i] !== 32'd0) begin
                errors++; $display("FAIL reset_count[%0d]: got %0d want 0", i, count[i]);
            end
        end
        checks++;
        if (enq_ready !== 1'b1) begin
            errors++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready);
        end
    endtask

    task automatic test_order;
        deq_ready = 1'b1;
        enq(3'd2, 16'd100);
        enq(3'd5, 16'd40);
        checks++;
        if (valid_q !== 8'h24) begin
            errors++; $display("FAIL order_valid_q: got %h want 24", valid_q);
        end
        serve(3'd5);
        checks++;
        if ({deq_valid, deq_flow, deq_len} !== {1'b1, 3'd5, 16'd40}) begin
            errors++;
            $display("FAIL order_first: got v%b f%0d l%0d want v1 f5 l40", deq_valid, deq_flow,
                     deq_len);
        end
        checks++;
        if (count[5] !== 32'd40) begin
            errors++; $display("FAIL order_count5: got %0d want 40", count[5]);
        end
        checks++;
        if (valid_q !== 8'h04) begin
            errors++; $display("FAIL order_valid_after: got %h want 04", valid_q);
        end
        @(negedge clk);
        checks++;
        if (deq_valid !== 1'b0) begin
            errors++; $display("FAIL order_drain: got %b want 0", deq_valid);
        end
        serve(3'd2);
        checks++;
        if ({deq_flow, deq_len} !== {3'd2, 16'd100}) begin
            errors++; $display("FAIL order_second: got f%0d l%0d want f2 l100", deq_flow, deq_len);
        end
        checks++;
        if (count[2] !== 32'd100 || count[5] !== 32'd40) begin
            errors++;
            $display("FAIL order_counts: got %0d/%0d want 100/40", count[2], count[5]);
        end
        @(negedge clk);
    endtask

    task automatic test_full;
        deq_ready = 1'b0;
        repeat (4) enq(3'd3, 16'd10);
        enq_valid = 1'b1; enq_flow = 3'd3; enq_len = 16'd99;
        #1;
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++; $display("FAIL full_enq_ready: got %b want 0", enq_ready);
        end
        enq_valid = 1'b0;
        @(negedge clk);
        serve(3'd3);
        checks++;
        if ({deq_flow, deq_len, count[3]} !== {3'd3, 16'd10, 32'd10}) begin
            errors++;
            $display("FAIL full_serve: got f%0d l%0d c%0d want f3 l10 c10", deq_flow, deq_len,
                     count[3]);
        end
        pick = 3'd3; pick_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({deq_valid, deq_len, count[3], valid_q[3]} !== {1'b1, 16'd10, 32'd10, 1'b1}) begin
            errors++;
            $display("FAIL full_hold: got v%b l%0d c%0d q%b want v1 l10 c10 q1", deq_valid,
                     deq_len, count[3], valid_q[3]);
        end
        pick_valid = 1'b0; deq_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (deq_valid !== 1'b0) begin
            errors++; $display("FAIL full_release: got %b want 0", deq_valid);
        end
        for (int i = 0; i < 3; i++) begin
            serve(3'd3);
            @(negedge clk);
        end
        checks++;
        if (count[3] !== 32'd40 || valid_q[3] !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got c%0d q%b want c40 q0", count[3], valid_q[3]);
        end
    endtask

    task automatic test_fair;
        enq(3'd1, 16'd250);
        enq(3'd1, 16'd220);
        enq(3'd1, 16'd60);
        checks++;
        if (count[1] !== 32'd30) begin
            errors++; $display("FAIL fair_join1: got %0d want 30", count[1]);
        end
        serve(3'd1); @(negedge clk);
        serve(3'd1); @(negedge clk);
        serve(3'd1);
        checks++;
        if (count[1] !== 32'd560) begin
            errors++; $display("FAIL fair_count1: got %0d want 560", count[1]);
        end
        @(negedge clk);
        enq(3'd6, 16'd60);
        checks++;
        if (count[6] !== 32'd500) begin
            errors++; $display("FAIL fair_join6: got %0d want 500", count[6]);
        end
        enq(3'd6, 16'd60);
        enq(3'd1, 16'd60);
        checks++;
        if (count[1] !== 32'd560 || count[6] !== 32'd500) begin
            errors++;
            $display("FAIL fair_push_only: got %0d/%0d want 560/500", count[1], count[6]);
        end
        serve(3'd6); @(negedge clk);
        serve(3'd1);
        checks++;
        if (deq_flow !== 3'd1 || count[1] !== 32'd620 || count[6] !== 32'd560) begin
            errors++;
            $display("FAIL fair_alt: got f%0d c1=%0d c6=%0d want f1 620 560", deq_flow, count[1],
                     count[6]);
        end
        @(negedge clk);
        serve(3'd6);
        checks++;
        if (count[6] !== 32'd620) begin
            errors++; $display("FAIL fair_count6: got %0d want 620", count[6]);
        end
        @(negedge clk);
    endtask

    task automatic test_stale;
        pick = 3'd4; pick_valid = 1'b1;
        repeat (3) @(negedge clk);
        pick_valid = 1'b0;
        checks++;
        if (deq_valid !== 1'b0 || count[4] !== 32'd0 || count[1] !== 32'd620) begin
            errors++;
            $display("FAIL stale_ignored: got v%b c4=%0d c1=%0d want v0 0 620", deq_valid,
                     count[4], count[1]);
        end
        enq(3'd4, 16'd30);
        checks++;
        if (count[4] !== 32'd560) begin
            errors++; $display("FAIL stale_join4: got %0d want 560", count[4]);
        end
        serve(3'd4);
        checks++;
        if ({deq_valid, deq_flow, count[4]} !== {1'b1, 3'd4, 32'd590}) begin
            errors++;
            $display("FAIL stale_idle_serve: got v%b f%0d c%0d want v1 f4 c590", deq_valid,
                     deq_flow, count[4]);
        end
        @(negedge clk);
    endtask

    task automatic test_norm;
        logic [7:0][31:0] pre;
        pre = {32'd0, 32'd620, 32'd40, 32'd590, 32'd40, 32'd100, 32'd620, 32'h7FFF_FFCE};
        force dut.count_q = pre;
        #1;
        release dut.count_q;
        enq(3'd0, 16'd100);
        checks++;
        if (count[0] !== 32'h7FFF_FFCE) begin
            errors++; $display("FAIL norm_preload: got %h want 7fffffce", count[0]);
        end
        serve(3'd0);
        checks++;
        if (count[0] !== 32'h8000_0032) begin
            errors++; $display("FAIL norm_add: got %h want 80000032", count[0]);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (count[0] !== 32'h4000_0032) begin
            errors++; $display("FAIL norm_count0: got %h want 40000032", count[0]);
        end
        checks++;
        if (count[1] !== 32'd0 || count[4] !== 32'd0 || count[6] !== 32'd0) begin
            errors++;
            $display("FAIL norm_clamp: got %0d/%0d/%0d want 0/0/0", count[1], count[4], count[6]);
        end
        enq(3'd7, 16'd5);
        checks++;
        if (count[7] !== 32'h3FFF_FFCE) begin
            errors++; $display("FAIL norm_vtime: got %h want 3fffffce", count[7]);
        end
        serve(3'd7);
        checks++;
        if (count[7] !== 32'h3FFF_FFD3 || deq_len !== 16'd5) begin
            errors++;
            $display("FAIL norm_after: got c%h l%0d want c3fffffd3 l5", count[7], deq_len);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        enq(3'd2, 16'd77);
        enq(3'd5, 16'd33);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (valid_q !== 8'h00 || count[2] !== 32'd0 || count[0] !== 32'd0 || deq_valid !== 1'b0)
        begin
            errors++;
            $display("FAIL midreset_state: got q%h c2=%0d c0=%0d v%b want q00 0 0 v0", valid_q,
                     count[2], count[0], deq_valid);
        end
        enq(3'd2, 16'd9);
        serve(3'd2);
        checks++;
        if ({deq_len, count[2]} !== {16'd9, 32'd9}) begin
            errors++;
            $display("FAIL midreset_discard: got l%0d c%0d want l9 c9", deq_len, count[2]);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; enq_valid = 1'b0; enq_flow = '0; enq_len = '0;
        pick = '0; pick_valid = 1'b0; deq_ready = 1'b1;
        test_reset();
        test_order();
        test_full();
        test_fair();
        test_stale();
        test_norm();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fq_flow_bank.md
Name: fq_flow_bank

Overview:
- Per-flow packet-descriptor store and service accountant for the fair queue; the counterpart of the min-count scheduler.
- Accepts descriptors (flow id, length) into per-flow FIFOs and publishes per-flow occupancy valids plus 32-bit service counts to the scheduler.
- Consumes the scheduler's registered pick, dequeues the head of the picked flow and adds its length to that flow's count.
- Sits between the classifier (enqueue side) and the transmit port (dequeue side).

Parameters:
- NUM_IN_LOG2, 3, log2 of flow count (8 flows).
- DEPTH_LOG2, 2, log2 of per-flow FIFO depth (4 entries).
- LEN_W, 16, width of packet length field in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enq_valid  in  1  descriptor offered
- enq_ready  out  1  descriptor accepted when enq_valid && enq_ready
- enq_flow  in  NUM_IN_LOG2  target flow
- enq_len  in  LEN_W  packet length, bytes
- count  out  32 x 2**NUM_IN_LOG2  per-flow service count (to scheduler)
- valid_q  out  1 x 2**NUM_IN_LOG2  flow non-empty (to scheduler valid inputs)
- pick  in  NUM_IN_LOG2  scheduler-selected flow
- pick_valid  in  1  pick meaningful
- deq_valid  out  1  descriptor presented
- deq_ready  in  1  transmit accepts
- deq_flow  out  NUM_IN_LOG2  flow of presented descriptor
- deq_len  out  LEN_W  length of presented descriptor

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values:
  - all FIFOs empty; valid_q all 0; count all 0; vtime 0.
  - deq_valid 0; deq_flow 0; deq_len 0; FSM in S_IDLE.
  - Reset mid-operation discards all held descriptors.
- enq_ready = !full[enq_flow], combinational; independent of FSM state.
- Enqueue to a flow empty at that edge: count[f] <= max(count[f], vtime), so idle flows cannot bank credit.
- Enqueue to a non-empty flow: push only, count unchanged.
- valid_q[f] and count[f] are registered; both reflect the FIFO state after the edge.
- Output slot: one register (deq_valid/deq_flow/deq_len). The slot is free when !deq_valid || deq_ready.
- FSM:
  - S_IDLE: if pick_valid && slot free && valid_q[pick], then:
    - pop the head of flow pick into the slot (deq_valid <= 1);
    - vtime <= count[pick];
    - count[pick] <= count[pick] + deq_len, with deq_len zero-extended to 32 bits;
    - go to S_HOLD.
  - S_IDLE: pick_valid with valid_q[pick] == 0 (stale pick) is ignored; stay in S_IDLE.
  - S_HOLD: one cycle, no service. This covers the scheduler's registered latency, so a stale pick never double-serves. Next state is S_NORM if any count[31] is set, else S_IDLE.
  - S_NORM: one cycle. Every count and vtime is reduced by 2**30, saturating at 0. Then go to S_IDLE. Enqueues in this cycle push normally; the max() uses the pre-normalised vtime, then normalises.
- Arithmetic: the 32-bit add never wraps, because S_NORM fires once bit 31 is set and LEN_W < 30.
- Simultaneous enqueue and dequeue on the same flow in one cycle:
  - both happen;
  - a full flow still refuses the enqueue (ready is computed from pre-pop occupancy);
  - the empty-flow max() rule applies only when occupancy before the edge is 0 and no pop occurs.
- Maximum service rate: one descriptor per 2 cycles (3 when normalising).
- deq_* are held stable while deq_valid && !deq_ready.

Decomposition:
- Package fq_pkg:
  - NUM_FLOWS = 2**NUM_IN_LOG2, COUNT_W = 32, NORM_STEP = 2**30;
  - typedef flow_id_t, len_t;
  - FSM enum state_t {S_IDLE, S_HOLD, S_NORM}.
- Sub-module fq_flow_fifo: one per flow, generate loop.
  - Interface: push, pop, din, dout, empty, full, occupancy.
  - Synchronous reset to empty; DEPTH_LOG2 parameter.

Test Plan:
- Reset with enqueues in flight → deq_valid=0, valid_q=8'h00, all count=0; enq_ready=1 on the first cycle after reset.
- Enqueue flow 2 len 100, flow 5 len 40, with a model scheduler (registered min pick) → flow 5 served first, then flow 2; count[5]=40, count[2]=100.
- Flow 3 enqueued 4x len 10 while deq_ready=0 → a fifth enqueue to flow 3 sees enq_ready=0; deq_len holds 10 until deq_ready=1; no duplicate service during S_HOLD.
- Flow 1 served to count 500, flow 6 idle then enqueued → count[6] set to vtime (500, not 0); service alternates fairly from there.
- Preload count[0] to 2**31-50, serve len 100 → S_NORM fires; count[0]=2**31+50-2**30; counts below 2**30 clamp to 0.
- Stale pick_valid with pick=4 and valid_q[4]=0 → no dequeue, FSM stays S_IDLE, counts unchanged.
